// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift/rotate opcodes, the shifter FSM state type and opcode helpers.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ROR = 3'd0,
        OP_ROL = 3'd1,
        OP_LSL = 3'd2,
        OP_LSR = 3'd3,
        OP_ASR = 3'd4
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } sru_state_t;

    // Codes 5..7 are reserved.
    function automatic logic op_is_reserved(input logic [OP_W-1:0] op);
        return op > OP_W'(OP_ASR);
    endfunction

    function automatic logic op_is_rotate(input logic [OP_W-1:0] op);
        return (op == OP_W'(OP_ROR)) || (op == OP_W'(OP_ROL));
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step move of the datapath by k positions (0..STEP) for one opcode.
module shift_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    parameter int unsigned K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [K_W-1:0]   k_i,
    input  shift_op_t        op_i,
    output logic [WIDTH-1:0] data_c_o,
    output logic             carry_c_o
);

    localparam int unsigned IW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] dbl_c;
    logic [2*WIDTH-1:0] rol_c;
    logic [IW-1:0]      lo_idx_c;
    logic [IW-1:0]      hi_idx_c;

    // Carry is the last bit to leave the word; the index arithmetic only matters for k >= 1.
    always_comb begin
        dbl_c     = {data_i, data_i};
        rol_c     = dbl_c << k_i;
        lo_idx_c  = IW'(32'(k_i) - 32'd1);
        hi_idx_c  = IW'(WIDTH - 32'(k_i));
        data_c_o  = data_i;
        carry_c_o = 1'b0;
        case (op_i)
            OP_ROR: begin
                data_c_o  = WIDTH'(dbl_c >> k_i);
                carry_c_o = data_c_o[WIDTH-1];
            end
            OP_ROL: begin
                data_c_o  = rol_c[2*WIDTH-1:WIDTH];
                carry_c_o = data_c_o[0];
            end
            OP_LSL: begin
                data_c_o  = data_i << k_i;
                carry_c_o = data_i[hi_idx_c];
            end
            OP_LSR: begin
                data_c_o  = data_i >> k_i;
                carry_c_o = data_i[lo_idx_c];
            end
            OP_ASR: begin
                data_c_o  = WIDTH'($signed(data_i) >>> k_i);
                carry_c_o = data_i[lo_idx_c];
            end
            default: ;
        endcase
        if (k_i == '0) begin
            carry_c_o = 1'b0;
        end
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// Iterative multi-cycle shift/rotate unit (ROR/ROL/LSL/LSR/ASR) with carry-out and valid/ready handshake.
module shift_rotate_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    localparam int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_err
);

    localparam int unsigned     K_W        = $clog2(STEP + 1);
    localparam int unsigned     IW         = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] AMT_WIDTH = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_STEP  = AMT_W'(STEP);

    sru_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    shift_op_t        op_q, op_d;
    logic             kill_q, kill_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_carry_q, out_carry_d;
    logic             out_err_q, out_err_d;

    logic             rsv_c;
    logic             kill_c;
    logic [AMT_W-1:0] eff_c;
    logic [K_W-1:0]   k_c;
    logic [WIDTH-1:0] step_data_c;
    logic             step_carry_c;

    // Effective amount; shifts past WIDTH on LSL/LSR lose the carry entirely.
    always_comb begin
        rsv_c  = op_is_reserved(in_op);
        kill_c = (in_amt > AMT_WIDTH) &&
                 ((in_op == OP_W'(OP_LSL)) || (in_op == OP_W'(OP_LSR)));
        if (rsv_c) begin
            eff_c = '0;
        end else if (op_is_rotate(in_op)) begin
            eff_c = AMT_W'(in_amt[IW-1:0]);
        end else begin
            eff_c = (in_amt > AMT_WIDTH) ? AMT_WIDTH : in_amt;
        end
        k_c = (rem_q >= AMT_STEP) ? K_W'(STEP) : K_W'(rem_q);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_shift_step (
        .data_i    (data_q),
        .k_i       (k_c),
        .op_i      (op_q),
        .data_c_o  (step_data_c),
        .carry_c_o (step_carry_c)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rem_d       = rem_q;
        op_d        = op_q;
        kill_d      = kill_q;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        out_err_d   = out_err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d = in_data;
                    rem_d  = eff_c;
                    kill_d = kill_c;
                    if (!rsv_c) begin
                        op_d = shift_op_t'(in_op);
                    end
                    if (eff_c == '0) begin
                        state_d     = S_DONE;
                        out_data_d  = in_data;
                        out_carry_d = 1'b0;
                        out_err_d   = rsv_c;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                data_d = step_data_c;
                rem_d  = rem_q - AMT_W'(k_c);
                if (rem_d == '0) begin
                    state_d     = S_DONE;
                    out_data_d  = step_data_c;
                    out_carry_d = step_carry_c & ~kill_q;
                    out_err_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            op_q        <= OP_ROR;
            kill_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            kill_q      <= kill_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Bench for shift_rotate_unit: three instances (STEP=4, 1, 32) share stimulus and are checked against a reference model.
module tb_shift_rotate_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [5:0]  in_amt;
    logic [2:0]  in_op;
    logic        out_ready;

    logic [2:0]  in_ready_w, out_valid_w, out_carry_w, out_err_w;
    logic [31:0] out_data_w [3];

    int          vectors = 0;
    int          miscompares = 0;

    logic [2:0]  obs_seen;
    logic [31:0] obs_data [3];
    logic [2:0]  obs_carry, obs_err;
    int          obs_lat [3];

    always #5 clk = ~clk;

    shift_rotate_unit #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
        .out_carry(out_carry_w[0]), .out_err(out_err_w[0]));

    shift_rotate_unit #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
        .out_carry(out_carry_w[1]), .out_err(out_err_w[1]));

    shift_rotate_unit #(.WIDTH(32), .STEP(32)) u_s32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_data(out_data_w[2]),
        .out_carry(out_carry_w[2]), .out_err(out_err_w[2]));

    function automatic int step_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 32;
    endfunction

    // Reference result {err, carry, data} computed from wide arithmetic.
    function automatic logic [33:0] ref_op(input logic [2:0] op, input logic [31:0] d,
                                           input logic [5:0] amt);
        logic [63:0] full;
        logic [31:0] r;
        logic        c;
        logic        e_rr;
        int          e;
        r = d; c = 1'b0; e_rr = 1'b0;
        case (op)
            3'd0: begin
                e = int'(amt) % 32;
                r = (e == 0) ? d : ((d >> e) | (d << (32 - e)));
                c = (e == 0) ? 1'b0 : r[31];
            end
            3'd1: begin
                e = int'(amt) % 32;
                r = (e == 0) ? d : ((d << e) | (d >> (32 - e)));
                c = (e == 0) ? 1'b0 : r[0];
            end
            3'd2: begin
                if (amt > 6'd32) begin r = '0; c = 1'b0; end
                else begin full = {32'b0, d} << amt; r = full[31:0]; c = full[32]; end
            end
            3'd3: begin
                if (amt > 6'd32) begin r = '0; c = 1'b0; end
                else begin full = {d, 32'b0} >> amt; r = full[63:32]; c = full[31]; end
            end
            3'd4: begin
                e = (amt > 6'd32) ? 32 : int'(amt);
                full = $signed({d, 32'b0}) >>> e;
                r = full[63:32]; c = full[31];
            end
            default: begin r = d; c = 1'b0; e_rr = 1'b1; end
        endcase
        return {e_rr, c, r};
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [5:0] amt, input int step);
        int eff;
        if (op > 3'd4) eff = 0;
        else if (op <= 3'd1) eff = int'(amt) % 32;
        else eff = (amt > 6'd32) ? 32 : int'(amt);
        return 1 + (eff + step - 1) / step;
    endfunction

    // Issue one op to all instances with out_ready held high and record each result and latency.
    task automatic do_op(input logic [2:0] op, input logic [31:0] d, input logic [5:0] amt);
        int guard;
        obs_seen = '0;
        guard = 0;
        while (in_ready_w !== 3'b111 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = op; in_data = d; in_amt = amt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = $urandom; in_amt = 6'($urandom); in_op = 3'($urandom);
        for (int cyc = 1; cyc <= 60 && obs_seen != 3'b111; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            for (int i = 0; i < 3; i++) begin
                if (!obs_seen[i] && out_valid_w[i]) begin
                    obs_seen[i] = 1'b1;
                    obs_data[i] = out_data_w[i];
                    obs_carry[i] = out_carry_w[i];
                    obs_err[i] = out_err_w[i];
                    obs_lat[i] = cyc;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({in_ready_w[i], out_valid_w[i], out_data_w[i], out_carry_w[i], out_err_w[i]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b data=%h c=%b err=%b, need rdy=1 vld=0 data=0 c=0 err=0",
                         i, in_ready_w[i], out_valid_w[i], out_data_w[i], out_carry_w[i], out_err_w[i]);
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (in_ready_w !== 3'b111 || out_valid_w !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_idle: rdy=%b vld=%b, need rdy=111 vld=000", in_ready_w, out_valid_w);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op   [8] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd2, 3'd2, 3'd0, 3'd6};
        logic [31:0] t_dat  [8] = '{32'h2, 32'h80000001, 32'hA, 32'h80000000, 32'h1, 32'h1, 32'h5, 32'h1234ABCD};
        logic [5:0]  t_amt  [8] = '{6'd3, 6'd33, 6'd10, 6'd40, 6'd32, 6'd33, 6'd0, 6'd5};
        logic [31:0] t_exp  [8] = '{32'h40000000, 32'h3, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h5, 32'h1234ABCD};
        logic        t_c    [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        t_err  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          t_eff  [8] = '{3, 1, 10, 32, 32, 32, 0, 0};
        int          exp_lat;
        for (int t = 0; t < 8; t++) begin
            do_op(t_op[t], t_dat[t], t_amt[t]);
            for (int i = 0; i < 3; i++) begin
                exp_lat = 1 + (t_eff[t] + step_of(i) - 1) / step_of(i);
                vectors++;
                if (obs_seen[i] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL dir%0d_step%0d_timeout: no out_valid seen", t, step_of(i));
                end else begin
                    vectors++;
                    if (obs_data[i] !== t_exp[t] || obs_carry[i] !== t_c[t] || obs_err[i] !== t_err[t]) begin
                        miscompares++;
                        $display("FAIL dir%0d_step%0d_result: data=%h c=%b err=%b, need data=%h c=%b err=%b",
                                 t, step_of(i), obs_data[i], obs_carry[i], obs_err[i], t_exp[t], t_c[t], t_err[t]);
                    end
                    vectors++;
                    if (obs_lat[i] != exp_lat) begin
                        miscompares++;
                        $display("FAIL dir%0d_step%0d_latency: got %0d need %0d", t, step_of(i), obs_lat[i], exp_lat);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] d;
        logic [5:0]  amt;
        logic [33:0] exp;
        int          exp_lat;
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 9) > 8) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            d = $urandom;
            case ($urandom_range(0, 6))
                0: amt = 6'd0;
                1: amt = 6'd31;
                2: amt = 6'd32;
                3: amt = 6'd33;
                4: amt = 6'd63;
                default: amt = 6'($urandom);
            endcase
            exp = ref_op(op, d, amt);
            do_op(op, d, amt);
            for (int i = 0; i < 3; i++) begin
                exp_lat = ref_lat(op, amt, step_of(i));
                vectors++;
                if (obs_seen[i] !== 1'b1 || {obs_err[i], obs_carry[i], obs_data[i]} !== exp || obs_lat[i] != exp_lat) begin
                    miscompares++;
                    $display("FAIL rand%0d_step%0d op=%0d d=%h amt=%0d: seen=%b err=%b c=%b data=%h lat=%0d, need err=%b c=%b data=%h lat=%0d",
                             n, step_of(i), op, d, amt, obs_seen[i], obs_err[i], obs_carry[i], obs_data[i], obs_lat[i],
                             exp[33], exp[32], exp[31:0], exp_lat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [33:0] exp;
        int          guard;
        d = $urandom;
        exp = ref_op(3'd0, d, 6'd5);
        guard = 0;
        while (in_ready_w !== 3'b111 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_data = d; in_amt = 6'd5;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom;
        guard = 0;
        while (out_valid_w !== 3'b111 && guard < 60) begin @(posedge clk); #1; guard++; end
        vectors++;
        if (out_valid_w !== 3'b111) begin
            miscompares++;
            $display("FAIL bp_valid_timeout: vld=%b need 111", out_valid_w);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (out_valid_w[i] !== 1'b1 || in_ready_w[i] !== 1'b0 ||
                    {out_err_w[i], out_carry_w[i], out_data_w[i]} !== exp) begin
                    miscompares++;
                    $display("FAIL bp_hold_step%0d_c%0d: vld=%b rdy=%b err=%b c=%b data=%h, need vld=1 rdy=0 err=%b c=%b data=%h",
                             step_of(i), cyc, out_valid_w[i], in_ready_w[i], out_err_w[i], out_carry_w[i], out_data_w[i],
                             exp[33], exp[32], exp[31:0]);
                end
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready_w !== 3'b111 || out_valid_w !== 3'b000) begin
            miscompares++;
            $display("FAIL bp_release: rdy=%b vld=%b, need rdy=111 vld=000", in_ready_w, out_valid_w);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (in_ready_w !== 3'b111 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd3; in_data = $urandom | 32'h80000000; in_amt = 6'd31;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({in_ready_w[i], out_valid_w[i], out_data_w[i], out_carry_w[i], out_err_w[i]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL midrst_step%0d: rdy=%b vld=%b data=%h c=%b err=%b, need rdy=1 vld=0 data=0 c=0 err=0",
                         step_of(i), in_ready_w[i], out_valid_w[i], out_data_w[i], out_carry_w[i], out_err_w[i]);
            end
        end
        @(negedge clk); rst = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid_w !== 3'b000 || in_ready_w !== 3'b111) begin
                miscompares++;
                $display("FAIL midrst_stale_c%0d: vld=%b rdy=%b, need vld=000 rdy=111", cyc, out_valid_w, in_ready_w);
            end
        end
        do_op(3'd0, 32'h2, 6'd3);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_seen[i] !== 1'b1 || obs_data[i] !== 32'h40000000 || obs_carry[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_recover_step%0d: seen=%b data=%h c=%b, need seen=1 data=40000000 c=0",
                         step_of(i), obs_seen[i], obs_data[i], obs_carry[i]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
